// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle for vga_mem_arbiter. It carries the VGA prefetch FIFO side, the
// CPU request/ack side and the single-port video RAM side. The arbiter uses
// the slave modport; the environment (CPU, RAM, VGA top level) uses master.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              vid_frame_start;
  logic              vid_pop;
  logic [DATA_W-1:0] vid_data;
  logic              vid_empty;
  logic              vid_underrun;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_frame_start, vid_pop,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vid_data, vid_empty, vid_underrun,
    output cpu_ack, cpu_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vid_frame_start, vid_pop,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vid_data, vid_empty, vid_underrun,
    input  cpu_ack, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one single-port synchronous video RAM between the
// VGA pixel prefetch path and the CPU. One RAM access per clk_50MHz cycle.
//
// The memory bus is registered: an access decided at a clock edge is on
// mem_addr/mem_we during the following cycle, and read data comes back on
// mem_rdata the cycle after that. Because of this two-stage pipeline up to
// two video reads can be outstanding, and both count toward occupancy.
//
// Optional build macro VGA_ARB_STATS_EN adds the underrun_count and
// cpu_stall_max statistics outputs.
//
// CPU FSM states:
//   state  | meaning
//   C_IDLE | no ack pending; a granted access may be on the RAM bus (c_pend)
//   C_ACK  | cpu_ack pulse cycle; cpu_rdata carries RAM read data for reads
module vga_mem_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FB_BASE    = 0,
  parameter int FB_WORDS   = 307200,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 4
) (
  input logic clk_50MHz,
  input logic clear,
  vga_mem_arbiter_if.slave bus
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0] underrun_count,
  output logic [15:0] cpu_stall_max
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = PW + 2;
  localparam int WW = $clog2(FB_WORDS + 1);
  localparam logic [OW-1:0]     LW_O    = OW'(LOW_WATER);
  localparam logic [OW-1:0]     DEPTH_O = OW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0]     FBW     = WW'(FB_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FB_BASE);

  typedef enum logic {C_IDLE, C_ACK} cpu_state_t;

  // prefetch FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              underrun;

  // video fetch pipeline: v_issue = read on RAM bus, v_valid = data on mem_rdata
  logic              v_issue, v_valid;
  logic [ADDR_W-1:0] vid_ptr;
  logic [WW-1:0]     words_left;

  // CPU side
  cpu_state_t        c_state;
  logic              c_pend, c_we, ack_q;

  // registered RAM bus
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic              fs, fetch_en, urgent, cpu_ok, grant_v, grant_c;
  logic              push, pop_ok, pop_empty;
  logic [OW-1:0]     occ;
  logic [ADDR_W-1:0] ptr_cur;

  // Arbitration for the next RAM slot. A frame start flushes everything, so
  // occupancy is taken as zero and the first fetch starts at the frame base.
  always_comb begin
    fs        = bus.vid_frame_start;
    fetch_en  = fs || (words_left != '0);
    occ       = fs ? '0 : (OW'(count) + OW'(v_issue) + OW'(v_valid));
    urgent    = fetch_en && (occ < LW_O);
    cpu_ok    = bus.cpu_req && (c_state == C_IDLE) && !c_pend;
    grant_v   = urgent || (!cpu_ok && fetch_en && (occ < DEPTH_O));
    grant_c   = cpu_ok && !urgent;
    ptr_cur   = fs ? BASE_A : vid_ptr;
    push      = v_valid && !fs;
    pop_ok    = bus.vid_pop && !fs && (count != '0);
    pop_empty = bus.vid_pop && !fs && (count == '0);
  end

  // RAM bus registers and video fetch pointer / remaining-word down-counter
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      v_issue    <= 1'b0;
      v_valid    <= 1'b0;
      c_pend     <= 1'b0;
      vid_ptr    <= BASE_A;
      words_left <= '0;
    end else begin
      v_issue <= grant_v;
      v_valid <= v_issue && !fs;
      c_pend  <= grant_c;
      we_q    <= grant_c && bus.cpu_we;
      if (grant_v) begin
        addr_q     <= ptr_cur;
        vid_ptr    <= ptr_cur + ADDR_W'(1);
        words_left <= (fs ? FBW : words_left) - WW'(1);
      end else if (grant_c) begin
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
      end
      if (fs && !grant_v) begin
        vid_ptr    <= BASE_A;
        words_left <= FBW;
      end
    end
  end

  // FIFO storage; contents are only visible through the count-gated head
  always_ff @(posedge clk_50MHz) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
  end

  // FIFO pointers, occupancy and sticky underrun flag
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      underrun <= 1'b0;
    end else if (fs) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      underrun <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop_ok)      count <= count + CW'(1);
      else if (!push && pop_ok) count <= count - CW'(1);
      if (pop_empty) underrun <= 1'b1;
    end
  end

  // CPU handshake FSM: ack one cycle after the access occupied the RAM bus
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      c_state <= C_IDLE;
      ack_q   <= 1'b0;
      c_we    <= 1'b0;
    end else if (c_state == C_IDLE) begin
      ack_q <= 1'b0;
      if (c_pend) begin
        c_state <= C_ACK;
        ack_q   <= 1'b1;
        c_we    <= we_q;
      end
    end else begin
      ack_q   <= 1'b0;
      c_state <= C_IDLE;
    end
  end

  assign bus.vid_data     = (count == '0) ? '0 : fifo_mem[rd_ptr];
  assign bus.vid_empty    = (count == '0);
  assign bus.vid_underrun = underrun;
  assign bus.cpu_ack      = ack_q;
  assign bus.cpu_rdata    = (ack_q && !c_we) ? bus.mem_rdata : '0;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_wdata    = wdata_q;

  // occupancy bound in arbitration keeps the FIFO from ever overflowing
  assert property (@(posedge clk_50MHz) disable iff (clear)
    !(push && !pop_ok && (count == DEPTH_C)));

`ifdef VGA_ARB_STATS_EN
  logic [15:0] ucnt, stall_cnt, stall_max;

  // saturating underrun counter and longest CPU wait before grant
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      ucnt      <= '0;
      stall_cnt <= '0;
      stall_max <= '0;
    end else begin
      if (pop_empty && (ucnt != 16'hFFFF)) ucnt <= ucnt + 16'd1;
      if (grant_c) begin
        if (stall_cnt > stall_max) stall_max <= stall_cnt;
        stall_cnt <= '0;
      end else if (cpu_ok && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign underrun_count = ucnt;
  assign cpu_stall_max  = stall_max;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a small frame so a whole frame fits
// in a short run. A read-first synchronous RAM model sits on the memory bus,
// preloaded with ram[a] = a*7+3.
module tb_vga_mem_arbiter;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int FB_WORDS = 40;

  logic clk_50MHz = 1'b0;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  vga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef VGA_ARB_STATS_EN
  logic [15:0] underrun_count, cpu_stall_max;
`endif

  vga_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_BASE(0), .FB_WORDS(FB_WORDS),
    .FIFO_DEPTH(16), .LOW_WATER(4)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .clear(clear),
    .bus(bus)
`ifdef VGA_ARB_STATS_EN
    ,
    .underrun_count(underrun_count),
    .cpu_stall_max(cpu_stall_max)
`endif
  );

  always #10 clk_50MHz = ~clk_50MHz;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 7 + 3);
  endfunction

  logic [7:0] ram [1024];
  logic [7:0] ram_q;
  always @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_q <= 8'h00;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      ram_q <= ram[bus.mem_addr[9:0]];
    end
  end
  assign bus.mem_rdata = ram_q;

  typedef struct {
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t cpu_vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
  endtask

  // CPU access with the video side idle: grant next cycle, ack the one after
  task automatic cpu_fixed(input vec_t v);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    tick();
    check("cpu_grant_we", bus.mem_we, v.we);
    check("cpu_grant_addr", bus.mem_addr, v.addr);
    if (v.we) check("cpu_grant_wdata", bus.mem_wdata, v.wdata);
    check("cpu_ack_early", bus.cpu_ack, 1'b0);
    tick();
    check("cpu_ack", bus.cpu_ack, 1'b1);
    check("cpu_rdata", bus.cpu_rdata, v.exp_rdata);
    bus.cpu_req = 1'b0;
    tick();
    check("cpu_ack_single", bus.cpu_ack, 1'b0);
  endtask

  // CPU read with bounded wait for the ack
  task automatic cpu_stream(input int addr);
    int n;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 19'(addr);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cpu_ack && n < 40);
    check("stream_ack", bus.cpu_ack, 1'b1);
    check("stream_rdata", bus.cpu_rdata, init_val(addr));
    bus.cpu_req = 1'b0;
    tick();
  endtask

  // pops every second cycle, checking frame data in address order
  task automatic pop_frame(input int npop);
    int n;
    n = 0;
    while (bus.vid_empty && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < npop; i++) begin
      check("pop_not_empty", bus.vid_empty, 1'b0);
      check("pop_data", bus.vid_data, init_val(i));
      bus.vid_pop = 1'b1;
      tick();
      bus.vid_pop = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_vecs[0] = '{1'b1, 19'h100, 8'hA5, 8'h00};
    cpu_vecs[1] = '{1'b0, 19'h100, 8'h00, 8'hA5};
    cpu_vecs[2] = '{1'b0, 19'h005, 8'h00, 8'h26};
    cpu_vecs[3] = '{1'b1, 19'h3FF, 8'h5A, 8'h00};
    cpu_vecs[4] = '{1'b0, 19'h3FF, 8'h00, 8'h5A};
    cpu_vecs[5] = '{1'b1, 19'h100, 8'h3C, 8'h00};
    cpu_vecs[6] = '{1'b0, 19'h100, 8'h00, 8'h3C};
    cpu_vecs[7] = '{1'b0, 19'h101, 8'h00, 8'h0A};

    bus.vid_frame_start = 1'b0;
    bus.vid_pop   = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    #1 clear = 1'b1;

    // reset state
    repeat (3) @(negedge clk_50MHz);
    check("rst_vid_empty", bus.vid_empty, 1'b1);
    check("rst_vid_data", bus.vid_data, 8'h00);
    check("rst_underrun", bus.vid_underrun, 1'b0);
    check("rst_cpu_ack", bus.cpu_ack, 1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_mem_addr", bus.mem_addr, 19'h0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_wdata", bus.mem_wdata, 8'h00);
    clear = 1'b0;
    repeat (5) tick();
    check("no_fetch_before_fs", bus.vid_empty, 1'b1);

    // first frame start: 16 consecutive reads from the base, then idle
    bus.vid_frame_start = 1'b1;
    tick();
    bus.vid_frame_start = 1'b0;
    for (int k = 0; k < 21; k++) begin
      check("fill_addr", bus.mem_addr, (k < 16) ? k : 15);
      check("fill_we", bus.mem_we, 1'b0);
      check("fill_empty", bus.vid_empty, (k < 2) ? 1'b1 : 1'b0);
      tick();
    end
    check("fill_head", bus.vid_data, init_val(0));

    // CPU table with a full FIFO
    for (int i = 0; i < 8; i++) cpu_fixed(cpu_vecs[i]);
    check("cpu_head_kept", bus.vid_data, init_val(0));

    // urgent video beats a simultaneous CPU request until occupancy reaches 4
    bus.vid_frame_start = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 19'h200;
    bus.cpu_wdata = 8'h77;
    tick();
    bus.vid_frame_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("urg_video_addr", bus.mem_addr, k);
      check("urg_video_we", bus.mem_we, 1'b0);
      tick();
    end
    check("urg_cpu_addr", bus.mem_addr, 19'h200);
    check("urg_cpu_we", bus.mem_we, 1'b1);
    check("urg_cpu_wdata", bus.mem_wdata, 8'h77);
    tick();
    check("urg_cpu_ack", bus.cpu_ack, 1'b1);
    check("urg_resume_addr", bus.mem_addr, 19'h4);
    check("urg_resume_we", bus.mem_we, 1'b0);
    bus.cpu_req = 1'b0;
    tick();
    check("urg_ack_single", bus.cpu_ack, 1'b0);

    // whole frame popped every 2 cycles against a CPU read stream
    bus.vid_frame_start = 1'b1;
    tick();
    bus.vid_frame_start = 1'b0;
    check("frame_restart_addr", bus.mem_addr, 19'h0);
    fork
      pop_frame(FB_WORDS);
      begin
        for (int j = 0; j < 10; j++) cpu_stream(32'h300 + j);
      end
    join
    repeat (10) tick();
    check("frame_end_empty", bus.vid_empty, 1'b1);
    check("frame_no_underrun", bus.vid_underrun, 1'b0);
`ifdef VGA_ARB_STATS_EN
    check("stats_underrun_zero", underrun_count, 16'd0);
`endif

    // pop while empty
    bus.vid_pop = 1'b1;
    tick();
    bus.vid_pop = 1'b0;
    check("underrun_set", bus.vid_underrun, 1'b1);
    check("underrun_data", bus.vid_data, 8'h00);
    check("underrun_empty", bus.vid_empty, 1'b1);
    tick();
    check("underrun_sticky", bus.vid_underrun, 1'b1);
`ifdef VGA_ARB_STATS_EN
    check("stats_underrun_one", underrun_count, 16'd1);
`endif

    // frame start with pop: pop ignored, underrun cleared
    bus.vid_frame_start = 1'b1;
    bus.vid_pop = 1'b1;
    tick();
    bus.vid_frame_start = 1'b0;
    bus.vid_pop = 1'b0;
    check("fs_clears_underrun", bus.vid_underrun, 1'b0);
    check("fs_pop_addr", bus.mem_addr, 19'h0);
    check("fs_pop_empty", bus.vid_empty, 1'b1);
    tick();
    check("fs2_pre_addr", bus.mem_addr, 19'h1);
    // second frame start with two reads in flight: neither may land in the FIFO
    bus.vid_frame_start = 1'b1;
    tick();
    bus.vid_frame_start = 1'b0;
    check("fs2_restart_addr", bus.mem_addr, 19'h0);
    check("fs2_discard_data", bus.vid_empty, 1'b1);
    tick();
    check("fs2_discard_issue", bus.vid_empty, 1'b1);
    check("fs2_next_addr", bus.mem_addr, 19'h1);
    tick();
    check("fs2_first_push", bus.vid_empty, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("fs2_order", bus.vid_data, init_val(i));
      bus.vid_pop = 1'b1;
      tick();
      bus.vid_pop = 1'b0;
      tick();
    end

    // clear during a pending CPU access: no ack, fetch disabled again
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 19'h210;
    @(posedge clk_50MHz);
    #2 clear = 1'b1;
    #1;
    check("clr_ack", bus.cpu_ack, 1'b0);
    check("clr_mem_we", bus.mem_we, 1'b0);
    check("clr_mem_addr", bus.mem_addr, 19'h0);
    check("clr_empty", bus.vid_empty, 1'b1);
    @(negedge clk_50MHz);
    bus.cpu_req = 1'b0;
    clear = 1'b0;
    repeat (3) begin
      tick();
      check("clr_no_ack", bus.cpu_ack, 1'b0);
    end
    check("clr_no_fetch", bus.vid_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
